// File: rtl/reservation_station.sv
// rtl/reservation_station.sv - reservation station holding dispatched instructions until operands are ready
//
// Accepts one dispatched instruction per cycle, snoops the CDB for pending
// operand tags and issues the lowest-index ready entry to the FU.
// Ports:
//   clk, reset                  clock (rising edge), async active-low reset
//   write, instr_in, dest_tag   dispatch from the instruction queue
//   src{1,2}_ready/_tag/_val    operand status at dispatch
//   cdb_valid, cdb_tag, cdb_val common data bus broadcast
//   fu_ready                    FU accepts an issue this cycle
//   stall                       back-pressure to the queue (one-slot margin)
//   issue_valid, issue_*        registered issue to the FU
//   count                       occupied entries
//   overflow                    sticky: write arrived with no free entry
module reservation_station #(
  parameter int RS_SIZE     = 4,
  parameter int INSTR_WIDTH = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int TAG_WIDTH   = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     write,
  input  logic [INSTR_WIDTH-1:0]   instr_in,
  input  logic [TAG_WIDTH-1:0]     dest_tag,
  input  logic                     src1_ready,
  input  logic [TAG_WIDTH-1:0]     src1_tag,
  input  logic [DATA_WIDTH-1:0]    src1_val,
  input  logic                     src2_ready,
  input  logic [TAG_WIDTH-1:0]     src2_tag,
  input  logic [DATA_WIDTH-1:0]    src2_val,
  input  logic                     cdb_valid,
  input  logic [TAG_WIDTH-1:0]     cdb_tag,
  input  logic [DATA_WIDTH-1:0]    cdb_val,
  input  logic                     fu_ready,
  output logic                     stall,
  output logic                     issue_valid,
  output logic [INSTR_WIDTH-1:0]   issue_instr,
  output logic [DATA_WIDTH-1:0]    issue_op1,
  output logic [DATA_WIDTH-1:0]    issue_op2,
  output logic [TAG_WIDTH-1:0]     issue_dest_tag,
  output logic [$clog2(RS_SIZE):0] count,
  output logic                     overflow
);

  localparam int IW = $clog2(RS_SIZE);
  localparam int CW = IW + 1;

  // entry state
  logic                   e_valid [RS_SIZE];
  logic [INSTR_WIDTH-1:0] e_instr [RS_SIZE];
  logic [TAG_WIDTH-1:0]   e_dest  [RS_SIZE];
  logic                   e_rdy1  [RS_SIZE];
  logic [TAG_WIDTH-1:0]   e_tag1  [RS_SIZE];
  logic [DATA_WIDTH-1:0]  e_val1  [RS_SIZE];
  logic                   e_rdy2  [RS_SIZE];
  logic [TAG_WIDTH-1:0]   e_tag2  [RS_SIZE];
  logic [DATA_WIDTH-1:0]  e_val2  [RS_SIZE];

  logic          alloc_found;
  logic [IW-1:0] alloc_idx;
  logic          sel_found;
  logic [IW-1:0] sel_idx;
  logic          wr_acc;
  logic          do_issue;
  logic          cap1_rdy;
  logic          cap2_rdy;
  logic [DATA_WIDTH-1:0] cap1_val;
  logic [DATA_WIDTH-1:0] cap2_val;

  // Free-slot and issue selection look only at registered state, so a slot
  // freed by this cycle's issue is not reusable until the next cycle and a
  // freshly written or woken entry cannot issue in the same cycle.
  always_comb begin
    alloc_found = 1'b0;
    alloc_idx   = '0;
    sel_found   = 1'b0;
    sel_idx     = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (!e_valid[i]) begin
        alloc_found = 1'b1;
        alloc_idx   = IW'(i);
      end
      if (e_valid[i] && e_rdy1[i] && e_rdy2[i]) begin
        sel_found = 1'b1;
        sel_idx   = IW'(i);
      end
    end
  end

  assign wr_acc   = write && alloc_found;
  assign do_issue = fu_ready && sel_found;

  // Operand capture at dispatch, including same-cycle CDB bypass.
  always_comb begin
    cap1_rdy = src1_ready || (cdb_valid && (cdb_tag == src1_tag));
    cap2_rdy = src2_ready || (cdb_valid && (cdb_tag == src2_tag));
    cap1_val = src1_ready ? src1_val : cdb_val;
    cap2_val = src2_ready ? src2_val : cdb_val;
  end

  assign stall = (CW'(RS_SIZE) - count) <= CW'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        e_valid[i] <= 1'b0;
        e_instr[i] <= '0;
        e_dest[i]  <= '0;
        e_rdy1[i]  <= 1'b0;
        e_tag1[i]  <= '0;
        e_val1[i]  <= '0;
        e_rdy2[i]  <= 1'b0;
        e_tag2[i]  <= '0;
        e_val2[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < RS_SIZE; i++) begin
        // CDB snoop: both operands of an entry may wake on one broadcast.
        if (cdb_valid && e_valid[i]) begin
          if (!e_rdy1[i] && (e_tag1[i] == cdb_tag)) begin
            e_rdy1[i] <= 1'b1;
            e_val1[i] <= cdb_val;
          end
          if (!e_rdy2[i] && (e_tag2[i] == cdb_tag)) begin
            e_rdy2[i] <= 1'b1;
            e_val2[i] <= cdb_val;
          end
        end
        if (do_issue && (sel_idx == IW'(i))) begin
          e_valid[i] <= 1'b0;
        end
        // The allocated slot is invalid, so it never collides with snoop or issue.
        if (wr_acc && (alloc_idx == IW'(i))) begin
          e_valid[i] <= 1'b1;
          e_instr[i] <= instr_in;
          e_dest[i]  <= dest_tag;
          e_rdy1[i]  <= cap1_rdy;
          e_tag1[i]  <= src1_tag;
          e_val1[i]  <= cap1_val;
          e_rdy2[i]  <= cap2_rdy;
          e_tag2[i]  <= src2_tag;
          e_val2[i]  <= cap2_val;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      issue_valid    <= 1'b0;
      issue_instr    <= '0;
      issue_op1      <= '0;
      issue_op2      <= '0;
      issue_dest_tag <= '0;
    end else begin
      issue_valid <= do_issue;
      if (do_issue) begin
        issue_instr    <= e_instr[sel_idx];
        issue_op1      <= e_val1[sel_idx];
        issue_op2      <= e_val2[sel_idx];
        issue_dest_tag <= e_dest[sel_idx];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      count <= count + CW'(wr_acc) - CW'(do_issue);
      if (write && !alloc_found) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_reservation_station.sv
// tb/tb_reservation_station.sv - self-checking bench for reservation_station
module tb_reservation_station;

  logic        clk = 1'b0;
  logic        reset;
  logic        write;
  logic [31:0] instr_in;
  logic [3:0]  dest_tag;
  logic        src1_ready, src2_ready;
  logic [3:0]  src1_tag, src2_tag;
  logic [31:0] src1_val, src2_val;
  logic        cdb_valid;
  logic [3:0]  cdb_tag;
  logic [31:0] cdb_val;
  logic        fu_ready;
  logic        stall;
  logic        issue_valid;
  logic [31:0] issue_instr, issue_op1, issue_op2;
  logic [3:0]  issue_dest_tag;
  logic [2:0]  count;
  logic        overflow;

  int n_checks = 0;
  int n_pass   = 0;

  reservation_station dut (
    .clk(clk), .reset(reset), .write(write), .instr_in(instr_in), .dest_tag(dest_tag),
    .src1_ready(src1_ready), .src1_tag(src1_tag), .src1_val(src1_val),
    .src2_ready(src2_ready), .src2_tag(src2_tag), .src2_val(src2_val),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_val(cdb_val), .fu_ready(fu_ready),
    .stall(stall), .issue_valid(issue_valid), .issue_instr(issue_instr),
    .issue_op1(issue_op1), .issue_op2(issue_op2), .issue_dest_tag(issue_dest_tag),
    .count(count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic drv(input logic wr, input logic [31:0] ins, input logic [3:0] dt,
                     input logic r1, input logic [3:0] t1, input logic [31:0] v1,
                     input logic r2, input logic [3:0] t2, input logic [31:0] v2,
                     input logic cv, input logic [3:0] ct, input logic [31:0] cval,
                     input logic fu);
    write = wr; instr_in = ins; dest_tag = dt;
    src1_ready = r1; src1_tag = t1; src1_val = v1;
    src2_ready = r2; src2_tag = t2; src2_val = v2;
    cdb_valid = cv; cdb_tag = ct; cdb_val = cval; fu_ready = fu;
  endtask

  task automatic idle(input logic fu);
    drv(0, 32'hDEAD_BEEF, 4'hF, 1, 4'h1, 32'hBAD1, 1, 4'h1, 32'hBAD2, 0, 4'h0, 0, fu);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    idle(0);
    repeat (2) @(posedge clk);
    #3;
    reset = 1'b1;
  endtask

  // ---------------- table-driven vectors ----------------
  typedef struct {
    logic wr; logic [31:0] instr; logic [3:0] dest;
    logic s1r; logic [3:0] s1t; logic [31:0] s1v;
    logic s2r; logic [3:0] s2t; logic [31:0] s2v;
    logic cv; logic [3:0] ct; logic [31:0] cval;
    logic fu;
    logic e_iv; logic [31:0] e_instr; logic [31:0] e_op1; logic [31:0] e_op2;
    logic [3:0] e_dest; logic [2:0] e_cnt; logic e_stall;
  } vec_t;

  vec_t vecs [11];

  // ---------------- behavioural model ----------------
  typedef struct {
    bit v; logic [31:0] instr; logic [3:0] dest;
    bit r1; logic [3:0] t1; logic [31:0] d1;
    bit r2; logic [3:0] t2; logic [31:0] d2;
  } ment_t;

  ment_t m [4];
  bit          m_iv, m_ovf;
  logic [31:0] m_instr, m_op1, m_op2;
  logic [3:0]  m_dest;

  task automatic model_reset();
    for (int j = 0; j < 4; j++) m[j] = '{default: 0};
    m_iv = 0; m_ovf = 0; m_instr = 0; m_op1 = 0; m_op2 = 0; m_dest = 0;
  endtask

  function automatic int model_count();
    int c = 0;
    for (int j = 0; j < 4; j++) if (m[j].v) c++;
    return c;
  endfunction

  // Advance the model across one clock edge using the currently driven inputs.
  task automatic model_step();
    int sel = -1;
    int al  = -1;
    ment_t nx [4];
    for (int j = 0; j < 4; j++) begin
      if (sel < 0 && m[j].v && m[j].r1 && m[j].r2) sel = j;
      if (al < 0 && !m[j].v) al = j;
      nx[j] = m[j];
    end
    if (cdb_valid) begin
      for (int j = 0; j < 4; j++) begin
        if (nx[j].v && !nx[j].r1 && nx[j].t1 == cdb_tag) begin nx[j].r1 = 1; nx[j].d1 = cdb_val; end
        if (nx[j].v && !nx[j].r2 && nx[j].t2 == cdb_tag) begin nx[j].r2 = 1; nx[j].d2 = cdb_val; end
      end
    end
    m_iv = fu_ready && (sel >= 0);
    if (m_iv) begin
      m_instr = m[sel].instr; m_op1 = m[sel].d1; m_op2 = m[sel].d2; m_dest = m[sel].dest;
      nx[sel].v = 0;
    end
    if (write) begin
      if (al < 0) m_ovf = 1;
      else begin
        nx[al].v = 1; nx[al].instr = instr_in; nx[al].dest = dest_tag;
        nx[al].t1 = src1_tag; nx[al].t2 = src2_tag;
        nx[al].r1 = src1_ready || (cdb_valid && cdb_tag == src1_tag);
        nx[al].r2 = src2_ready || (cdb_valid && cdb_tag == src2_tag);
        nx[al].d1 = src1_ready ? src1_val : cdb_val;
        nx[al].d2 = src2_ready ? src2_val : cdb_val;
      end
    end
    for (int j = 0; j < 4; j++) m[j] = nx[j];
  endtask

  initial begin
    vecs[0]  = '{1, 32'h00A52020, 3, 1, 0, 5, 1, 0, 7, 0, 0, 0, 1,   0, 0, 0, 0, 0, 1, 0};
    vecs[1]  = '{0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 1,   1, 32'h00A52020, 5, 7, 3, 0, 0};
    vecs[2]  = '{0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 1,   0, 32'h00A52020, 5, 7, 3, 0, 0};
    vecs[3]  = '{1, 32'h11111111, 4, 0, 2, 0, 1, 0, 32'h55, 0, 0, 0, 1,   0, 32'h00A52020, 5, 7, 3, 1, 0};
    vecs[4]  = '{0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 1,   0, 32'h00A52020, 5, 7, 3, 1, 0};
    vecs[5]  = '{0, 0, 0, 1, 0, 0, 1, 0, 0, 1, 3, 32'h99, 1,   0, 32'h00A52020, 5, 7, 3, 1, 0};
    vecs[6]  = '{0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 1,   0, 32'h00A52020, 5, 7, 3, 1, 0};
    vecs[7]  = '{0, 0, 0, 1, 0, 0, 1, 0, 0, 1, 2, 32'h1234, 1,   0, 32'h00A52020, 5, 7, 3, 1, 0};
    vecs[8]  = '{0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 1,   1, 32'h11111111, 32'h1234, 32'h55, 4, 0, 0};
    vecs[9]  = '{1, 32'h22222222, 5, 1, 0, 32'hA, 0, 6, 0, 1, 6, 9, 1,   0, 32'h11111111, 32'h1234, 32'h55, 4, 1, 0};
    vecs[10] = '{0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 1,   1, 32'h22222222, 32'hA, 9, 5, 0, 0};

    do_reset();
    chk("reset_count", count, 0);
    chk("reset_issue_valid", issue_valid, 0);
    chk("reset_issue_instr", issue_instr, 0);
    chk("reset_issue_op1", issue_op1, 0);
    chk("reset_issue_op2", issue_op2, 0);
    chk("reset_issue_dest", issue_dest_tag, 0);
    chk("reset_overflow", overflow, 0);
    chk("reset_stall", stall, 0);

    // Basic issue, CDB wake-up, and dispatch bypass.
    for (int k = 0; k < 11; k++) begin
      drv(vecs[k].wr, vecs[k].instr, vecs[k].dest, vecs[k].s1r, vecs[k].s1t, vecs[k].s1v,
          vecs[k].s2r, vecs[k].s2t, vecs[k].s2v, vecs[k].cv, vecs[k].ct, vecs[k].cval, vecs[k].fu);
      tick();
      chk($sformatf("vec%0d_issue_valid", k), issue_valid, vecs[k].e_iv);
      chk($sformatf("vec%0d_issue_instr", k), issue_instr, vecs[k].e_instr);
      chk($sformatf("vec%0d_issue_op1", k), issue_op1, vecs[k].e_op1);
      chk($sformatf("vec%0d_issue_op2", k), issue_op2, vecs[k].e_op2);
      chk($sformatf("vec%0d_issue_dest", k), issue_dest_tag, vecs[k].e_dest);
      chk($sformatf("vec%0d_count", k), count, vecs[k].e_cnt);
      chk($sformatf("vec%0d_stall", k), stall, vecs[k].e_stall);
    end

    // Fill to capacity, overflow, then drain in index order.
    do_reset();
    for (int k = 0; k < 5; k++) begin
      drv(1, 32'h100 + k, 4'(k + 1), 1, 0, k, 1, 0, k + 10, 0, 0, 0, 0);
      tick();
      chk($sformatf("fill%0d_count", k), count, (k < 4) ? k + 1 : 4);
      chk($sformatf("fill%0d_stall", k), stall, (k >= 2) ? 1 : 0);
      chk($sformatf("fill%0d_overflow", k), overflow, (k == 4) ? 1 : 0);
      chk($sformatf("fill%0d_issue_valid", k), issue_valid, 0);
    end
    for (int k = 0; k < 4; k++) begin
      idle(1);
      tick();
      chk($sformatf("drain%0d_issue_valid", k), issue_valid, 1);
      chk($sformatf("drain%0d_issue_instr", k), issue_instr, 32'h100 + k);
      chk($sformatf("drain%0d_issue_op1", k), issue_op1, k);
      chk($sformatf("drain%0d_issue_op2", k), issue_op2, k + 10);
      chk($sformatf("drain%0d_issue_dest", k), issue_dest_tag, k + 1);
      chk($sformatf("drain%0d_count", k), count, 3 - k);
    end
    idle(1);
    tick();
    chk("drain_end_issue_valid", issue_valid, 0);
    chk("drain_end_overflow_sticky", overflow, 1);

    // Two entries woken by a single broadcast.
    do_reset();
    drv(1, 32'hA0, 1, 0, 5, 0, 1, 0, 3, 0, 0, 0, 1);
    tick();
    chk("wake_wrA_issue_valid", issue_valid, 0);
    drv(1, 32'hB0, 2, 0, 5, 0, 0, 5, 0, 0, 0, 0, 1);
    tick();
    chk("wake_wrB_issue_valid", issue_valid, 0);
    for (int k = 0; k < 2; k++) begin
      idle(1);
      tick();
      chk($sformatf("wake_wait%0d_issue_valid", k), issue_valid, 0);
    end
    drv(0, 0, 0, 1, 0, 0, 1, 0, 0, 1, 5, 32'h77, 1);
    tick();
    chk("wake_bcast_issue_valid", issue_valid, 0);
    idle(1);
    tick();
    chk("wake_first_issue_valid", issue_valid, 1);
    chk("wake_first_instr", issue_instr, 32'hA0);
    chk("wake_first_op1", issue_op1, 32'h77);
    chk("wake_first_op2", issue_op2, 3);
    idle(1);
    tick();
    chk("wake_second_issue_valid", issue_valid, 1);
    chk("wake_second_instr", issue_instr, 32'hB0);
    chk("wake_second_op1", issue_op1, 32'h77);
    chk("wake_second_op2", issue_op2, 32'h77);
    chk("wake_second_count", count, 0);

    // Asynchronous reset with entries held and an issue in flight.
    do_reset();
    for (int k = 0; k < 3; k++) begin
      drv(1, 32'h300 + k, 4'(k + 1), 1, 0, k, 1, 0, k, 0, 0, 0, 0);
      tick();
    end
    idle(1);
    tick();
    chk("midrst_pre_issue_valid", issue_valid, 1);
    chk("midrst_pre_count", count, 2);
    #2;
    reset = 1'b0;
    #1;
    chk("midrst_count", count, 0);
    chk("midrst_issue_valid", issue_valid, 0);
    chk("midrst_stall", stall, 0);
    #2;
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("midrst_post%0d_issue_valid", k), issue_valid, 0);
      chk($sformatf("midrst_post%0d_count", k), count, 0);
    end

    // Randomized traffic against the reference model.
    do_reset();
    model_reset();
    for (int c = 0; c < 800; c++) begin
      drv(($urandom_range(0, 9) < 6), $urandom, 4'($urandom_range(1, 15)),
          $urandom_range(0, 1), 4'($urandom_range(1, 6)), $urandom,
          $urandom_range(0, 1), 4'($urandom_range(1, 6)), $urandom,
          $urandom_range(0, 1), 4'($urandom_range(1, 6)), $urandom,
          ($urandom_range(0, 9) < 5));
      model_step();
      tick();
      chk($sformatf("rnd%0d_issue_valid", c), issue_valid, m_iv);
      if (m_iv) begin
        chk($sformatf("rnd%0d_issue_instr", c), issue_instr, m_instr);
        chk($sformatf("rnd%0d_issue_op1", c), issue_op1, m_op1);
        chk($sformatf("rnd%0d_issue_op2", c), issue_op2, m_op2);
        chk($sformatf("rnd%0d_issue_dest", c), issue_dest_tag, m_dest);
      end
      chk($sformatf("rnd%0d_count", c), count, model_count());
      chk($sformatf("rnd%0d_stall", c), stall, (4 - model_count()) <= 1);
      chk($sformatf("rnd%0d_overflow", c), overflow, m_ovf);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/reservation_station.md
Name: reservation_station

Overview:
- Consumer end of the instruction-queue → RS dispatch interface.
- Accepts one dispatched instruction per cycle (write + instr_in) with its operand status, and holds it until both operands are ready.
- Snoops the common data bus (CDB) for pending operand tags and issues one ready instruction per cycle to a functional unit (FU).
- Back-pressures the queue through stall.

Parameters:
RS_SIZE, 4, number of entries (2..8)
INSTR_WIDTH, 32, instruction width
DATA_WIDTH, 32, operand/result width
TAG_WIDTH, 4, producer tag width; tag 0 is reserved as "no producer"

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
write  in  1  dispatch valid from queue
instr_in  in  INSTR_WIDTH  dispatched instruction
dest_tag  in  TAG_WIDTH  tag this instruction will broadcast
src1_ready  in  1  operand 1 value valid
src1_tag  in  TAG_WIDTH  producer tag of operand 1 when not ready
src1_val  in  DATA_WIDTH  operand 1 value when ready
src2_ready / src2_tag / src2_val  in  1 / TAG_WIDTH / DATA_WIDTH  same for operand 2
cdb_valid  in  1  CDB broadcast valid
cdb_tag  in  TAG_WIDTH  broadcast tag
cdb_val  in  DATA_WIDTH  broadcast result
fu_ready  in  1  FU can accept an issue this cycle
stall  out  1  queue must not issue
issue_valid  out  1  issue strobe to FU (registered)
issue_instr  out  INSTR_WIDTH  issued instruction
issue_op1 / issue_op2  out  DATA_WIDTH  issued operands
issue_dest_tag  out  TAG_WIDTH  issued destination tag
count  out  log2(RS_SIZE)+1  occupied entries
overflow  out  1  sticky: write arrived with no free entry

Behaviour:
- Reset (reset=0, async):
  - All entries invalid.
  - count=0, issue_valid=0, issue_instr/op1/op2/dest_tag=0, overflow=0.
  - stall=0 once reset is released.
- Per-entry state: valid, instr, dest_tag, and for each operand {rdy, tag, val}.
- stall (combinational) = (RS_SIZE − count) <= 1.
  - One-slot margin is mandatory: the queue registers its issue, so write arrives one cycle after stall is sampled.
- Allocation: on write, the instruction goes into the lowest-index free entry.
  - If no entry is free: drop the instruction, set overflow=1 (cleared only by reset).
- Operand capture at write:
  - srcN_ready=1 → store srcN_val, rdy=1.
  - Else if cdb_valid and cdb_tag==srcN_tag → store cdb_val, rdy=1 (same-cycle bypass).
  - Else store the tag, rdy=0.
- CDB snoop: each cycle cdb_valid=1, every valid entry with rdy=0 and a matching tag captures cdb_val and sets rdy. Both operands may match the same broadcast.
- Issue selection: uses registered entry state only.
  - Eligible = valid and both rdy.
  - Pick the lowest-index eligible entry.
  - An entry written or woken by the CDB in cycle N is first eligible in cycle N+1 (no combinational wake-to-issue path).
- Issue:
  - If fu_ready=1 and an entry is eligible: at the clock edge, issue_* ← entry fields, issue_valid ← 1, entry valid ← 0.
  - Otherwise issue_valid ← 0 and issue_* hold their values.
  - Latency: ready-at-write instruction written in cycle N → issue_valid high in cycle N+2 at the earliest.
- count next = count + (write accepted) − (issue). Simultaneous write and issue leave count unchanged; the freed slot is reusable from the next cycle only.
- A write while full with a simultaneous issue is still an overflow: the freed slot is not visible in the same cycle.
- The write path ignores instr_in and operands when write=0.
- Reset mid-operation: all entries are discarded immediately; an issue in flight is cancelled (issue_valid=0).

Test Plan:
1. Reset, then write instr 0x00A52020 with both operands ready (5, 7), dest_tag=3, fu_ready=1 → issue_valid=1 two cycles later with op1=5, op2=7, dest_tag=3; count returns to 0.
2. Write with src1_ready=0, src1_tag=2; hold 3 cycles; CDB tag=2, val=0x1234 → issue one cycle after the broadcast with op1=0x1234; no issue before it.
3. Write with src2_tag=6 in the same cycle as cdb_valid, tag=6, val=9 → captured via bypass; issues with op2=9 without a further broadcast.
4. RS_SIZE=4, fu_ready=0, 3 ready writes → stall=1 at count=3. Force a 4th write → count=4. Force a 5th → overflow=1, count stays 4. Raise fu_ready → entries issue in index order 0,1,2,3, one per cycle.
5. Entries 0 and 1 both waiting on tag 5; one CDB broadcast of tag 5 → both wake. Issue order: entry 0, then entry 1 on consecutive cycles.
6. Assert reset while 2 entries are valid and issue_valid=1 → count=0, issue_valid=0, stall=0 immediately; no issue after release.
